elevator_scan_ctrl: RTL and testbench

Parametrised multi-floor elevator controller: latches one-hot floor requests into a pending set and serves them with SCAN (sweep) ordering. It models per-floor travel time and a door-open dwell, and reports car position, direction and door state. It replaces the single-request fixed-5-floor elevator block and sits between the request-button logic and the car/door drive stubs.

---
 rtl/elevator_pkg.sv | 26 ++
 rtl/elevator_timer.sv | 36 +++
 rtl/elevator_scan_ctrl.sv | 267 ++++++++++++++++++++++++++
 tb/tb_elevator_scan_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// elevator_pkg: shared types and constants for the SCAN elevator controller.
//   state_t          car state enumeration (IDLE, MOVE, DOOR)
//   floor_width()    index width for a count of items (minimum 1 bit)
//   DEF_*            default parameter values for elevator_scan_ctrl
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  localparam int DEF_FLOORS        = 8;
  localparam int DEF_TRAVEL_CYCLES = 4;
  localparam int DEF_DOOR_CYCLES   = 3;

  // Width needed to hold an index 0..n-1; never narrower than one bit.
  function automatic int floor_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/elevator_timer.sv
// elevator_timer: loadable down-counter with a terminal-count flag.
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset (count returns to 0)
//   load      reload count with load_val (has priority over counting)
//   load_val  reload value; the flag asserts load_val+1 enabled cycles later
//   en        decrement while non-zero
//   done      high while count is zero
module elevator_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] count;

  // Down-counter: load wins, then decrement, saturating at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= {W{1'b0}};
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != {W{1'b0}})) begin
      count <= count - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

  assign done = (count == {W{1'b0}});

endmodule

// File: rtl/elevator_scan_ctrl.sv
// elevator_scan_ctrl: multi-floor elevator controller with SCAN ordering.
// Requests are latched into a pending set; the car sweeps in one direction
// serving every pending floor it reaches, and reverses only after a door
// stop (or from IDLE) when nothing is left ahead.
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   floor_req  one bit per floor, OR-ed into pending every edge
//   emerg      (only with ELEV_EMERGENCY_EN) emergency recall to floor 0
//   floor_pos  current floor (binary)
//   pending    outstanding requests
//   dir_up     sweep direction, 1 = up
//   moving     high in MOVE
//   door_open  high in DOOR
//   arrive     one-cycle pulse on DOOR entry
// Optional feature macro: ELEV_EMERGENCY_EN (adds the emerg input).
module elevator_scan_ctrl
  import elevator_pkg::*;
#(
  parameter  int FLOORS        = DEF_FLOORS,
  parameter  int TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
  parameter  int DOOR_CYCLES   = DEF_DOOR_CYCLES,
  localparam int FW            = floor_width(FLOORS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLOORS-1:0] floor_req,
`ifdef ELEV_EMERGENCY_EN
  input  logic              emerg,
`endif
  output logic [FW-1:0]     floor_pos,
  output logic [FLOORS-1:0] pending,
  output logic              dir_up,
  output logic              moving,
  output logic              door_open,
  output logic              arrive
);

  localparam int TW = floor_width(TRAVEL_CYCLES);
  localparam int DW = floor_width(DOOR_CYCLES);
  localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_LOAD   = DW'(DOOR_CYCLES - 1);
  localparam logic [FLOORS-1:0] ONE_HOT0 = {{(FLOORS-1){1'b0}}, 1'b1};
  localparam logic [FW-1:0] TOP_FLOOR  = FW'(FLOORS - 1);

  state_t            state;
  state_t            state_n;
  logic [FW-1:0]     floor_n;
  logic [FW-1:0]     floor_step;
  logic              dir_n;
  logic [FLOORS-1:0] pending_n;
  logic [FLOORS-1:0] served;
  logic [FLOORS-1:0] above_mask;
  logic [FLOORS-1:0] below_mask;
  logic              req_above;
  logic              req_below;
  logic              req_ahead;
  logic              req_behind;
  logic              here_req;
  logic              at_top;
  logic              at_bottom;
  logic              at_end;
  logic              enter_door;
  logic              trav_load;
  logic              door_load;
  logic              trav_done;
  logic              door_done;
  logic              home_stop;
  logic              exit_to_idle;

`ifdef ELEV_EMERGENCY_EN
  logic              emerg_hold;
  assign home_stop    = emerg_hold && (floor_step == {FW{1'b0}});
  assign exit_to_idle = emerg_hold;
`else
  assign home_stop    = 1'b0;
  assign exit_to_idle = 1'b0;
`endif

  // Floors strictly above / below the car, as bit masks over pending.
  always_comb begin
    above_mask = {FLOORS{1'b0}};
    below_mask = {FLOORS{1'b0}};
    for (int i = 0; i < FLOORS; i++) begin
      above_mask[i] = (FW'(i) > floor_pos);
      below_mask[i] = (FW'(i) < floor_pos);
    end
  end

  assign req_above  = |(pending & above_mask);
  assign req_below  = |(pending & below_mask);
  assign req_ahead  = dir_up ? req_above : req_below;
  assign req_behind = dir_up ? req_below : req_above;
  assign here_req   = pending[floor_pos];
  assign at_top     = (floor_pos == TOP_FLOOR);
  assign at_bottom  = (floor_pos == {FW{1'b0}});
  assign at_end     = dir_up ? at_top : at_bottom;
  assign floor_step = dir_up ? (floor_pos + FW'(1)) : (floor_pos - FW'(1));

  elevator_timer #(.W(TW)) u_travel_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (trav_load),
    .load_val (TRAVEL_LOAD),
    .en       (state == MOVE),
    .done     (trav_done)
  );

  elevator_timer #(.W(DW)) u_door_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (door_load),
    .load_val (DOOR_LOAD),
    .en       (state == DOOR),
    .done     (door_done)
  );

  // Next-state, timer control, and pending-set update.
  always_comb begin
    state_n    = state;
    floor_n    = floor_pos;
    dir_n      = dir_up;
    enter_door = 1'b0;
    trav_load  = 1'b0;
    door_load  = 1'b0;
    case (state)
      IDLE: begin
        // Up is tested before down, so an idle car prefers going up.
        if (here_req) begin
          state_n    = DOOR;
          enter_door = 1'b1;
        end else if (req_above) begin
          state_n   = MOVE;
          dir_n     = 1'b1;
          trav_load = 1'b1;
        end else if (req_below) begin
          state_n   = MOVE;
          dir_n     = 1'b0;
          trav_load = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      MOVE: begin
        if (!trav_done) begin
          state_n = MOVE;
        end else if (at_end) begin
          // Unreachable while a request lies ahead; keeps floor_pos in range.
          state_n = IDLE;
        end else begin
          floor_n   = floor_step;
          trav_load = 1'b1;
          if (pending[floor_step] || home_stop) begin
            state_n    = DOOR;
            enter_door = 1'b1;
          end else begin
            state_n = MOVE;
          end
        end
      end
      DOOR: begin
        // A fresh call for this floor is absorbed and reopens the full dwell.
        if (floor_req[floor_pos]) begin
          state_n   = DOOR;
          door_load = 1'b1;
        end else if (!door_done) begin
          state_n = DOOR;
        end else if (exit_to_idle) begin
          state_n = IDLE;
        end else if (req_ahead) begin
          state_n   = MOVE;
          trav_load = 1'b1;
        end else if (req_behind) begin
          state_n   = MOVE;
          dir_n     = ~dir_up;
          trav_load = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

`ifdef ELEV_EMERGENCY_EN
    // Emergency recall overrides every normal transition.
    if (emerg) begin
      dir_n      = 1'b0;
      floor_n    = floor_pos;
      enter_door = 1'b0;
      trav_load  = 1'b0;
      door_load  = 1'b0;
      if (state == MOVE) begin
        if (!trav_done) begin
          state_n = MOVE;
        end else if (at_bottom) begin
          state_n    = DOOR;
          enter_door = 1'b1;
        end else begin
          floor_n   = floor_pos - FW'(1);
          trav_load = 1'b1;
          if (floor_pos == FW'(1)) begin
            state_n    = DOOR;
            enter_door = 1'b1;
          end else begin
            state_n = MOVE;
          end
        end
      end else if (at_bottom) begin
        state_n    = DOOR;
        enter_door = (state != DOOR);
        door_load  = 1'b1;
      end else begin
        state_n   = MOVE;
        trav_load = 1'b1;
      end
    end else begin
      state_n = state_n;
    end
`endif

    door_load = door_load | enter_door;
    // The floor the car is (or will be) standing at with the door open.
    if (state_n == DOOR) begin
      served = ONE_HOT0 << floor_n;
    end else begin
      served = {FLOORS{1'b0}};
    end
    pending_n = (pending | floor_req) & ~served;
`ifdef ELEV_EMERGENCY_EN
    if (emerg) begin
      pending_n = {FLOORS{1'b0}};
    end else begin
      pending_n = pending_n;
    end
`endif
  end

  // State register with registered outputs derived from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      floor_pos <= {FW{1'b0}};
      pending   <= {FLOORS{1'b0}};
      dir_up    <= 1'b1;
      moving    <= 1'b0;
      door_open <= 1'b0;
      arrive    <= 1'b0;
`ifdef ELEV_EMERGENCY_EN
      emerg_hold <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      floor_pos <= floor_n;
      pending   <= pending_n;
      dir_up    <= dir_n;
      moving    <= (state_n == MOVE);
      door_open <= (state_n == DOOR);
      arrive    <= enter_door;
`ifdef ELEV_EMERGENCY_EN
      // Remember the recall until its final door dwell has finished.
      emerg_hold <= emerg | (emerg_hold & ~((state == DOOR) && (state_n != DOOR)));
`endif
    end
  end

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed bench for elevator_scan_ctrl (FLOORS=8, TRAVEL_CYCLES=4,
// DOOR_CYCLES=3). Inputs change 1 time unit after a rising edge and outputs
// are checked at that same point, i.e. away from the active edge.
module tb_elevator_scan_ctrl;

  logic       clk;
  logic       reset;
  logic [7:0] floor_req;
  logic [2:0] floor_pos;
  logic [7:0] pending;
  logic       dir_up;
  logic       moving;
  logic       door_open;
  logic       arrive;
`ifdef ELEV_EMERGENCY_EN
  logic       emerg;
`endif

  int checks = 0;
  int errors = 0;

  elevator_scan_ctrl #(
    .FLOORS        (8),
    .TRAVEL_CYCLES (4),
    .DOOR_CYCLES   (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .floor_req (floor_req),
`ifdef ELEV_EMERGENCY_EN
    .emerg     (emerg),
`endif
    .floor_pos (floor_pos),
    .pending   (pending),
    .dir_up    (dir_up),
    .moving    (moving),
    .door_open (door_open),
    .arrive    (arrive)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    reset     = 1'b0;
    floor_req = 8'h00;
`ifdef ELEV_EMERGENCY_EN
    emerg     = 1'b0;
`endif
    step(2);
    check("rst_floor", 32'(floor_pos), 32'd0);
    check("rst_pending", 32'(pending), 32'h00);
    check("rst_dir", 32'(dir_up), 32'd1);
    check("rst_moving", 32'(moving), 32'd0);
    check("rst_door", 32'(door_open), 32'd0);
    check("rst_arrive", 32'(arrive), 32'd0);
    reset = 1'b1;

    // Scenario 1: single request for floor 3 from floor 0.
    floor_req = 8'h08;
    step(1);
    floor_req = 8'h00;
    check("s1_pending", 32'(pending), 32'h08);
    check("s1_idle", 32'(moving), 32'd0);
    step(1);
    check("s1_move", 32'(moving), 32'd1);
    check("s1_dir", 32'(dir_up), 32'd1);
    step(3);
    check("s1_f0_hold", 32'(floor_pos), 32'd0);
    step(1);
    check("s1_f1", 32'(floor_pos), 32'd1);
    step(4);
    check("s1_f2", 32'(floor_pos), 32'd2);
    check("s1_f2_noarrive", 32'(arrive), 32'd0);
    step(4);
    check("s1_f3", 32'(floor_pos), 32'd3);
    check("s1_arrive", 32'(arrive), 32'd1);
    check("s1_door", 32'(door_open), 32'd1);
    check("s1_stop", 32'(moving), 32'd0);
    check("s1_served", 32'(pending), 32'h00);
    step(1);
    check("s1_arrive_pulse", 32'(arrive), 32'd0);
    check("s1_door2", 32'(door_open), 32'd1);
    step(1);
    check("s1_door3", 32'(door_open), 32'd1);
    step(1);
    check("s1_door_close", 32'(door_open), 32'd0);
    check("s1_idle_end", 32'(moving), 32'd0);

    // Scenario 2: 3 -> 6 with extra calls at 5 and 1 during the move.
    floor_req = 8'h40;
    step(1);
    floor_req = 8'h00;
    step(1);
    check("s2_move", 32'(moving), 32'd1);
    floor_req = 8'h22;
    step(1);
    floor_req = 8'h00;
    check("s2_pending", 32'(pending), 32'h62);
    step(7);
    check("s2_f5", 32'(floor_pos), 32'd5);
    check("s2_f5_arrive", 32'(arrive), 32'd1);
    check("s2_f5_pending", 32'(pending), 32'h42);
    step(3);
    check("s2_leave5", 32'(moving), 32'd1);
    check("s2_leave5_dir", 32'(dir_up), 32'd1);
    step(4);
    check("s2_f6", 32'(floor_pos), 32'd6);
    check("s2_f6_door", 32'(door_open), 32'd1);
    check("s2_f6_pending", 32'(pending), 32'h02);
    step(2);
    check("s2_f6_dir_kept", 32'(dir_up), 32'd1);
    step(1);
    check("s2_reverse", 32'(dir_up), 32'd0);
    check("s2_reverse_move", 32'(moving), 32'd1);
    step(20);
    check("s2_f1", 32'(floor_pos), 32'd1);
    check("s2_f1_arrive", 32'(arrive), 32'd1);
    step(3);
    check("s2_idle", 32'(door_open), 32'd0);
    check("s2_idle_dir", 32'(dir_up), 32'd0);

    // Scenario 3: hall call for the current floor while the door is open.
    floor_req = 8'h02;
    step(1);
    floor_req = 8'h00;
    step(1);
    check("s3_arrive", 32'(arrive), 32'd1);
    check("s3_door", 32'(door_open), 32'd1);
    step(1);
    floor_req = 8'h02;
    step(1);
    floor_req = 8'h00;
    check("s3_cleared", 32'(pending), 32'h00);
    check("s3_no_rearrive", 32'(arrive), 32'd0);
    step(1);
    check("s3_no_rearrive2", 32'(arrive), 32'd0);
    step(1);
    check("s3_extended", 32'(door_open), 32'd1);
    step(1);
    check("s3_closed", 32'(door_open), 32'd0);

    // Scenario 4: move 1 -> 4, then calls at 0 and 7 together.
    floor_req = 8'h10;
    step(1);
    floor_req = 8'h00;
    step(13);
    check("s4_f4", 32'(floor_pos), 32'd4);
    check("s4_f4_door", 32'(door_open), 32'd1);
    step(3);
    check("s4_idle", 32'(moving), 32'd0);
    floor_req = 8'h81;
    step(1);
    floor_req = 8'h00;
    check("s4_pending", 32'(pending), 32'h81);
    step(1);
    check("s4_up_first", 32'(dir_up), 32'd1);
    step(12);
    check("s4_f7", 32'(floor_pos), 32'd7);
    check("s4_f7_pending", 32'(pending), 32'h01);
    step(3);
    check("s4_down", 32'(dir_up), 32'd0);
    check("s4_top_held", 32'(floor_pos), 32'd7);
    step(27);
    check("s4_f1_pass", 32'(floor_pos), 32'd1);
    check("s4_f1_moving", 32'(moving), 32'd1);
    step(1);
    check("s4_f0", 32'(floor_pos), 32'd0);
    check("s4_f0_arrive", 32'(arrive), 32'd1);
    check("s4_f0_pending", 32'(pending), 32'h00);
    step(3);
    check("s4_idle_end", 32'(door_open), 32'd0);

    // Scenario 5: asynchronous reset between floors 2 and 3.
    floor_req = 8'h20;
    step(1);
    floor_req = 8'h00;
    step(9);
    check("s5_f2", 32'(floor_pos), 32'd2);
    step(1);
    #2;
    reset = 1'b0;
    #1;
    check("s5_rst_floor", 32'(floor_pos), 32'd0);
    check("s5_rst_pending", 32'(pending), 32'h00);
    check("s5_rst_dir", 32'(dir_up), 32'd1);
    check("s5_rst_moving", 32'(moving), 32'd0);
    step(1);
    reset = 1'b1;
    step(5);
    check("s5_stay_floor", 32'(floor_pos), 32'd0);
    check("s5_stay_idle", 32'(moving), 32'd0);
    check("s5_stay_door", 32'(door_open), 32'd0);

`ifdef ELEV_EMERGENCY_EN
    // Emergency recall while moving up past floor 5.
    floor_req = 8'h80;
    step(1);
    floor_req = 8'h00;
    step(21);
    check("em_f5", 32'(floor_pos), 32'd5);
    emerg     = 1'b1;
    floor_req = 8'h40;
    step(1);
    floor_req = 8'h00;
    check("em_pending", 32'(pending), 32'h00);
    check("em_dir", 32'(dir_up), 32'd0);
    begin : wait_home
      int n;
      n = 0;
      while ((door_open !== 1'b1) && (n < 80)) begin
        step(1);
        n++;
      end
    end
    check("em_home", 32'(floor_pos), 32'd0);
    check("em_door", 32'(door_open), 32'd1);
    step(6);
    check("em_door_held", 32'(door_open), 32'd1);
    emerg = 1'b0;
    step(2);
    check("em_door_tail", 32'(door_open), 32'd1);
    step(1);
    check("em_idle", 32'(door_open), 32'd0);
    check("em_idle_move", 32'(moving), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
